// File: rtl/simon_keyexp_stream_if.sv
// -----------------------------------------------------------------------------
// simon_keyexp_stream_if
// Bundles the control, key-load, round-key stream and table read signals of
// the SIMON key-schedule engine.
//   start      : pulse, accept key and (re)start expansion
//   key        : M*N key words, key word 0 in the least significant N bits
//   busy       : expansion in progress
//   done       : all T keys valid in the table
//   key_valid  : key_out/key_idx carry a new round key this cycle
//   key_out    : streamed round key
//   key_idx    : round index of key_out
//   rd_addr    : table read address
//   rd_key     : table word at rd_addr, one cycle later
// master drives start/key/rd_addr, slave is the key-schedule engine.
// -----------------------------------------------------------------------------
interface simon_keyexp_stream_if #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int AW = 5
);
    logic             start;
    logic [M*N-1:0]   key;
    logic             busy;
    logic             done;
    logic             key_valid;
    logic [N-1:0]     key_out;
    logic [AW-1:0]    key_idx;
    logic [AW-1:0]    rd_addr;
    logic [N-1:0]     rd_key;

    modport master (
        output start, key, rd_addr,
        input  busy, done, key_valid, key_out, key_idx, rd_key
    );

    modport slave (
        input  start, key, rd_addr,
        output busy, done, key_valid, key_out, key_idx, rd_key
    );
endinterface

// File: rtl/simon_keyexp_stream.sv
// -----------------------------------------------------------------------------
// simon_keyexp_stream
// Parametrised SIMON key-schedule engine. A start pulse loads M key words into
// a sliding window; each GEN cycle emits the oldest window word as the next
// round key, writes it to an internal T-entry table and shifts in a freshly
// generated word. A new start aborts any run in progress.
// Ports:
//   clk  : rising-edge clock
//   nR   : asynchronous active-low reset
//   bus  : simon_keyexp_stream_if.slave (start/key in, stream and status out,
//          table read port rd_addr -> rd_key with one cycle of latency)
// -----------------------------------------------------------------------------
module simon_keyexp_stream #(
    parameter int          N  = 16,
    parameter int          M  = 4,
    parameter int          T  = 32,
    // z0; bit j is the j-th sequence element
    parameter logic [61:0] Z  = 62'b0110011100001101010010001011111_0110011100001101010010001011111,
    parameter int          AW = 5
) (
    input logic                    clk,
    input logic                    nR,
    simon_keyexp_stream_if.slave   bus
);

    localparam int IW = (T > 1) ? $clog2(T) : 1;

    generate
        if (M < 2 || M > 4) begin : g_bad_m
            $error("simon_keyexp_stream: M must be 2, 3 or 4");
        end
        if (AW < IW) begin : g_bad_aw
            $error("simon_keyexp_stream: AW too narrow for T");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;

    state_t         state_q;
    logic [N-1:0]   win_q [M];
    logic [AW-1:0]  idx_q;
    logic [5:0]     zi_q;
    logic           busy_q;
    logic           done_q;
    logic           key_valid_q;
    logic [N-1:0]   key_out_q;
    logic [AW-1:0]  key_idx_q;

    // Table: plain array (no reset) plus a per-entry valid bitmap that is
    // cleared on reset, so a freshly reset table reads as all zeros.
    logic [N-1:0]   table_mem [T];
    logic [T-1:0]   valid_q;
    logic [N-1:0]   rd_data_q;
    logic           rd_ok_q;

    logic [N-1:0]   key_words  [M];
    logic [N-1:0]   win_shift  [M];
    logic [N-1:0]   tmp_w;
    logic [N-1:0]   new_word;
    logic           wr_en;
    logic           rd_in_range;

    function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int r);
        return (x >> r) | (x << (N - r));
    endfunction

    // Unpack the key bus and build the shifted window (new word enters on top).
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_win
            assign key_words[gi] = bus.key[gi*N +: N];
            if (gi == M - 1) begin : g_top
                assign win_shift[gi] = new_word;
            end else begin : g_mid
                assign win_shift[gi] = win_q[gi+1];
            end
        end
    endgenerate

    // Next key word. ~win[0] ^ 3 folds the round constant c = 2^N - 4.
    always_comb begin
        tmp_w = ror(win_q[M-1], 3);
        if (M == 4) begin
            tmp_w = tmp_w ^ win_q[1];
        end
        new_word = ~win_q[0] ^ tmp_w ^ ror(tmp_w, 1) ^ N'(Z[zi_q]) ^ N'(3);
    end

    // start has priority, so an aborted GEN cycle neither streams nor writes.
    assign wr_en       = (state_q == GEN) && !bus.start;
    assign rd_in_range = ({1'b0, bus.rd_addr} < (AW+1)'(T));

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q     <= IDLE;
            for (int i = 0; i < M; i++) begin
                win_q[i] <= '0;
            end
            idx_q       <= '0;
            zi_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            key_out_q   <= '0;
            key_idx_q   <= '0;
        end else begin
            key_valid_q <= 1'b0;
            if (bus.start) begin
                state_q <= LOAD;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    LOAD: begin
                        win_q   <= key_words;
                        idx_q   <= '0;
                        zi_q    <= '0;
                        state_q <= GEN;
                    end
                    GEN: begin
                        key_out_q   <= win_q[0];
                        key_idx_q   <= idx_q;
                        key_valid_q <= 1'b1;
                        win_q       <= win_shift;
                        idx_q       <= idx_q + AW'(1);
                        zi_q        <= (zi_q == 6'd61) ? 6'd0 : zi_q + 6'd1;
                        if (idx_q == AW'(T - 1)) begin
                            state_q <= DONE;
                        end
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Valid bitmap and read qualifier. Sampling valid_q before this edge's
    // update gives read-before-write behaviour, matching the data array.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            valid_q <= '0;
            rd_ok_q <= 1'b0;
        end else begin
            rd_ok_q <= rd_in_range && valid_q[bus.rd_addr[IW-1:0]];
            if (wr_en) begin
                valid_q[idx_q[IW-1:0]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[idx_q[IW-1:0]] <= win_q[0];
        end
        rd_data_q <= table_mem[bus.rd_addr[IW-1:0]];
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_out   = key_out_q;
    assign bus.key_idx   = key_idx_q;
    assign bus.rd_key    = rd_ok_q ? rd_data_q : '0;

endmodule
